// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, redirect flushes,
// data-memory wait freezing with a timeout trap, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            id_is_branch,
    input  logic            id_redirect,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [4:0]      mem_rd,
    input  logic            mem_mem_read,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_we,
    output logic            if_id_we,
    output logic            id_ex_we,
    output logic            ex_mem_we,
    output logic            mem_wb_we,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_flush,
    output logic            mem_wb_flush,
    output logic            err,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WW:0]     wait_inc;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_hit, mem_hit, load_use, br_haz, data_haz, mem_freeze;

    // Register zero never carries a real dependency.
    always_comb begin
        ex_hit  = (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
        mem_hit = (mem_rd != 5'd0) &&
                  ((id_uses_rs1 && mem_rd == id_rs1) || (id_uses_rs2 && mem_rd == id_rs2));
        load_use   = ex_mem_read && ex_hit;
        br_haz     = id_is_branch && ((ex_reg_write && ex_hit) || (mem_mem_read && mem_hit));
        data_haz   = load_use || br_haz;
        mem_freeze = (state_q != S_ERR) && mem_req && !mem_ready;
    end

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!reset) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
            {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
        end else if (state_q == S_ERR) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
        end else if (mem_freeze) begin
            // Whole pipe holds; the bubble goes into WB so nothing retires twice.
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
            mem_wb_flush = 1'b1;
        end else if (data_haz) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_redirect) begin
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wait_inc   = {1'b0, wait_cnt_q} + (WW + 1)'(1);
        case (state_q)
            S_RUN: begin
                if (mem_freeze) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // Timeout wins over a ready arriving in the same cycle.
                if (wait_inc >= (WW + 1)'(TIMEOUT)) begin
                    state_d = S_ERR;
                end else if (mem_ready) begin
                    state_d = S_RUN;
                end else begin
                    wait_cnt_d = wait_inc[WW-1:0];
                end
            end
            default: state_d = S_ERR;
        endcase

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_we && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        if (if_id_flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err       = (state_q == S_ERR);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNTW    = 4;
    localparam int CMAX    = (1 << CNTW) - 1;

    // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb} we, {if_id, id_ex, ex_mem, mem_wb} flush
    localparam logic [8:0] V_RST = 9'b00000_1111;
    localparam logic [8:0] V_ERR = 9'b00000_0000;
    localparam logic [8:0] V_FRZ = 9'b00000_0001;
    localparam logic [8:0] V_HAZ = 9'b00111_0100;
    localparam logic [8:0] V_RED = 9'b11111_1000;
    localparam logic [8:0] V_NRM = 9'b11111_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic id_uses_rs1, id_uses_rs2, id_is_branch, id_redirect;
    logic ex_reg_write, ex_mem_read, mem_mem_read, mem_req, mem_ready;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, err;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: 0 = running, 1 = waiting on memory, 2 = trapped
    int m_mode = 0, m_waited = 0, m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_branch(id_is_branch), .id_redirect(id_redirect),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .err(err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return r != 5'd0 && ((id_uses_rs1 && id_rs1 == r) || (id_uses_rs2 && id_rs2 == r));
    endfunction

    function automatic logic [8:0] model_ctrl();
        bit hazard;
        hazard = (ex_mem_read && reads(ex_rd)) ||
                 (id_is_branch && ((ex_reg_write && reads(ex_rd)) || (mem_mem_read && reads(mem_rd))));
        if (!reset) return V_RST;
        if (m_mode == 2) return V_ERR;
        if (mem_req && !mem_ready) return V_FRZ;
        if (hazard) return V_HAZ;
        if (id_redirect) return V_RED;
        return V_NRM;
    endfunction

    // Every-cycle compare; outputs are sampled mid-cycle with inputs settled.
    always @(negedge clk) begin
        logic [8:0] exp_v;
        if (!reset) begin
            m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        end
        exp_v = model_ctrl();
        chk("ctrl", {7'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {7'd0, exp_v});
        chk("err", {15'd0, err}, {15'd0, m_mode == 2});
        chk("stall_cnt", {12'd0, stall_cnt}, 16'(m_stall));
        chk("flush_cnt", {12'd0, flush_cnt}, 16'(m_flush));
        if (reset) begin
            if (!exp_v[8] && m_stall < CMAX) m_stall++;
            if (exp_v[3] && m_flush < CMAX) m_flush++;
            if (m_mode == 0 && mem_req && !mem_ready) begin
                m_mode = 1; m_waited = 0;
            end else if (m_mode == 1) begin
                m_waited++;
                if (m_waited >= TIMEOUT) m_mode = 2;
                else if (mem_ready) m_mode = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_branch = 0; id_redirect = 0;
        ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_pc_we", {15'd0, pc_we}, 16'd0);
        chk("rst_mem_wb_flush", {15'd0, mem_wb_flush}, 16'd1);
        chk("rst_stall_cnt", {12'd0, stall_cnt}, 16'd0);
        tick();
        reset = 1'b1;
        #1;

        // Load-use on rs1
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        #1;
        chk("lu_pc_we", {15'd0, pc_we}, 16'd0);
        chk("lu_id_ex_flush", {15'd0, id_ex_flush}, 16'd1);
        chk("lu_id_ex_we", {15'd0, id_ex_we}, 16'd1);
        tick(); idle(); #1;
        chk("lu_stall_cnt", {12'd0, stall_cnt}, 16'd1);

        // Branch operand hazard outranks redirect
        id_is_branch = 1; id_rs2 = 7; id_uses_rs2 = 1; ex_reg_write = 1; ex_rd = 7; id_redirect = 1;
        #1;
        chk("br_pc_we", {15'd0, pc_we}, 16'd0);
        chk("br_if_id_flush", {15'd0, if_id_flush}, 16'd0);
        tick(); idle(); #1;
        chk("br_flush_cnt", {12'd0, flush_cnt}, 16'd0);

        // Plain redirect, then a dependency on x0
        id_redirect = 1;
        #1;
        chk("red_if_id_flush", {15'd0, if_id_flush}, 16'd1);
        chk("red_pc_we", {15'd0, pc_we}, 16'd1);
        tick(); idle();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        #1;
        chk("x0_pc_we", {15'd0, pc_we}, 16'd1);
        chk("red_flush_cnt", {12'd0, flush_cnt}, 16'd1);
        tick(); idle();

        // Three frozen cycles, then ready
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_mem_wb_flush", {15'd0, mem_wb_flush}, 16'd1);
            chk("frz_pc_we", {15'd0, pc_we}, 16'd0);
            tick();
        end
        mem_ready = 1;
        #1;
        chk("rdy_pc_we", {15'd0, pc_we}, 16'd1);
        tick(); idle(); #1;
        chk("frz_stall_cnt", {12'd0, stall_cnt}, 16'd5);

        // Timeout trap is sticky until reset
        mem_req = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("to_err", {15'd0, err}, 16'd1);
        chk("to_pc_we", {15'd0, pc_we}, 16'd0);
        chk("to_mem_wb_flush", {15'd0, mem_wb_flush}, 16'd0);
        mem_ready = 1;
        tick(); tick();
        chk("to_sticky", {15'd0, err}, 16'd1);
        reset = 1'b0;
        #1;
        chk("to_rst_err", {15'd0, err}, 16'd0);
        chk("to_rst_if_id_flush", {15'd0, if_id_flush}, 16'd1);
        idle();
        tick();
        reset = 1'b1;
        #1;
        chk("to_after_rst_pc_we", {15'd0, pc_we}, 16'd1);

        // Stall counter saturation
        ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", {12'd0, stall_cnt}, 16'd15);
        idle();
        do_reset();

        // Random traffic over a tiny register space so dependencies are frequent
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset        = ($urandom_range(0, 99) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            id_is_branch = ($urandom_range(0, 3) == 0);
            id_redirect  = ($urandom_range(0, 3) == 0);
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_mem_read  = ($urandom_range(0, 3) == 0);
            mem_mem_read = ($urandom_range(0, 3) == 0);
            mem_req      = (m_mode == 1) || ($urandom_range(0, 9) < 3);
            mem_ready    = 1'($urandom_range(0, 1));
        end
        tick();
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of consecutive memory-wait cycles before entering ERR.
REQ-002 Parameter CNTW, default 16, SHALL be the width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each  source register fields of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-007 id_is_branch  in  1  ID instruction compares operands in ID (branch/jalr).
REQ-008 id_redirect  in  1  ID resolved a taken branch/jump; NPC selects target.
REQ-009 ex_rd  in  5  EX destination register.
REQ-010 ex_reg_write, ex_mem_read  in  1 each  EX instruction writes RF / is a load.
REQ-011 mem_rd  in  5  MEM destination register.
REQ-012 mem_mem_read  in  1  MEM instruction is a load.
REQ-013 mem_req  in  1  MEM stage performs a data-memory access this cycle.
REQ-014 mem_ready  in  1  data memory has completed the access this cycle.
REQ-015 pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage-register write enables.
REQ-016 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  stage-register clear (bubble).
REQ-017 err  out  1  sticky memory-timeout error.
REQ-018 stall_cnt, flush_cnt  out  CNTW each  saturating performance counters.

Function
REQ-019 The FSM SHALL have three states: RUN, WAIT, ERR, encoded internally.
REQ-020 mem_freeze SHALL be (mem_req & ~mem_ready) in RUN or WAIT.
REQ-021 load_use SHALL be ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-022 br_haz SHALL be id_is_branch & (RAW match on ex_rd with ex_reg_write, or on mem_rd with mem_mem_read), with rd!=0, using the rs1/rs2 use qualifiers.
REQ-023 Priority SHALL be ERR > mem_freeze > (load_use | br_haz) > id_redirect > normal.
REQ-024 mem_freeze SHALL drive all *_we=0, all flushes=0 except mem_wb_flush=1, combinationally in the same cycle.
REQ-025 A data hazard SHALL drive pc_we=0, if_id_we=0, id_ex_flush=1, id_ex_we=1, ex_mem_we=1, mem_wb_we=1, other flushes 0.
REQ-026 id_redirect without a higher-priority condition SHALL drive all *_we=1 and if_id_flush=1.
REQ-027 Normal operation SHALL drive all *_we=1 and all flushes 0.
REQ-028 RUN->WAIT on mem_freeze; WAIT->RUN on mem_ready, with that cycle advancing per REQ-023 with freeze removed.
REQ-029 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle with mem_ready=0; reaching TIMEOUT SHALL transition to ERR.
REQ-030 ERR SHALL hold all *_we=0, all flushes 0, err=1 until reset; the ERR transition takes precedence over a same-cycle mem_ready.
REQ-031 stall_cnt SHALL increment by 1 each cycle pc_we=0 outside reset, saturating at all-ones.
REQ-032 flush_cnt SHALL increment by 1 each cycle if_id_flush=1 outside reset, saturating at all-ones.
REQ-033 Control outputs SHALL be combinational from state and inputs; counters, err and state SHALL be registered.

Reset
REQ-034 reset=0 SHALL asynchronously force state=RUN, wait counter=0, err=0, stall_cnt=0, flush_cnt=0.
REQ-035 While reset=0, all *_we SHALL be 0 and all flushes SHALL be 1.
REQ-036 Reset asserted mid-WAIT or in ERR SHALL return to RUN on the first clk edge after release, with no residual stall.

Verification
REQ-037 ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle: pc_we=0, if_id_we=0, id_ex_flush=1; stall_cnt +1.
REQ-038 id_is_branch=1, id_rs2=7, id_uses_rs2=1, ex_reg_write=1, ex_rd=7, id_redirect=1 -> data-hazard outputs, if_id_flush=0, flush_cnt unchanged.
REQ-039 id_redirect=1, no hazard -> if_id_flush=1, all we=1, flush_cnt +1; ex_rd=0 matching rs1=0 -> no stall.
REQ-040 mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles with mem_wb_flush=1, state WAIT, RUN after ready cycle; stall_cnt +3.
REQ-041 TIMEOUT=4, mem_req=1, mem_ready held 0 -> err=1 after 4 WAIT cycles, all we=0; later mem_ready=1 does not recover; reset=0 clears err.
REQ-042 CNTW=4, 20 consecutive load-use stalls -> stall_cnt holds 15.
